// File: rtl/dmx_pkg.sv
// -----------------------------------------------------------------------------
// dmx_pkg
// Shared definitions for the DMX channel store: address/data widths, channel
// count, the DMX start code and the arbiter state encoding.
// -----------------------------------------------------------------------------
package dmx_pkg;

    localparam int DMX_ADDR_W = 9;
    localparam int DMX_DATA_W = 8;
    localparam int DMX_NUM_CH = 512;

    localparam logic [DMX_DATA_W-1:0] DMX_START_CODE = 8'h00;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_SERVE = 1'b1
    } dmx_state_e;

endpackage

// File: rtl/dmx_channel_ram.sv
// -----------------------------------------------------------------------------
// dmx_channel_ram
// 512x8 channel store with one synchronous write port and one synchronous
// read port. Contents are not reset; the arbiter sweeps them after reset.
//
// Ports:
//   clk      system clock
//   wr_en    write enable
//   wr_addr  write channel address
//   wr_data  write channel value
//   rd_en    read enable; rd_data holds its value while low
//   rd_addr  read channel address
//   rd_data  registered read value
// -----------------------------------------------------------------------------
module dmx_channel_ram
    import dmx_pkg::*;
(
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DMX_ADDR_W-1:0] wr_addr,
    input  logic [DMX_DATA_W-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [DMX_ADDR_W-1:0] rd_addr,
    output logic [DMX_DATA_W-1:0] rd_data
);

    logic [DMX_DATA_W-1:0] mem [DMX_NUM_CH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/dmx_channel_arbiter.sv
// -----------------------------------------------------------------------------
// dmx_channel_arbiter
// Owns the DMX channel store. N_REQ write sources share the write port through
// round-robin arbitration (valid/ready); dmx_writer reads have priority and
// never share a cycle with a requester write. After reset or a clear pulse the
// whole store is swept to CLR_VAL.
//
// Ports:
//   clk            system clock
//   reset          asynchronous active-low reset
//   clear          pulse: start a clear sweep
//   req_valid      per-requester write request
//   req_addr       flattened 9-bit channel addresses, requester i at [9i+8:9i]
//   req_data       flattened 8-bit channel values, requester i at [8i+7:8i]
//   req_ready      one-hot write accept, write commits on this edge
//   request_addr   channel requested by dmx_writer
//   request_pulse  read strobe
//   addr           registered echo of request_addr
//   data           registered channel value for addr
//   busy           high while a clear sweep runs
// -----------------------------------------------------------------------------
module dmx_channel_arbiter
    import dmx_pkg::*;
#(
    parameter int                    N_REQ   = 4,
    parameter logic [DMX_DATA_W-1:0] CLR_VAL = 8'h00
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clear,
    input  logic [N_REQ-1:0]               req_valid,
    input  logic [DMX_ADDR_W*N_REQ-1:0]    req_addr,
    input  logic [DMX_DATA_W*N_REQ-1:0]    req_data,
    output logic [N_REQ-1:0]               req_ready,
    input  logic [DMX_ADDR_W-1:0]          request_addr,
    input  logic                           request_pulse,
    output logic [DMX_ADDR_W-1:0]          addr,
    output logic [DMX_DATA_W-1:0]          data,
    output logic                           busy
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    dmx_state_e            state;
    logic [DMX_ADDR_W-1:0] sweep_cnt;
    logic [PTR_W-1:0]      rr_ptr;

    logic [DMX_ADDR_W-1:0] req_addr_a [N_REQ];
    logic [DMX_DATA_W-1:0] req_data_a [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign req_addr_a[g] = req_addr[g*DMX_ADDR_W +: DMX_ADDR_W];
        assign req_data_a[g] = req_data[g*DMX_DATA_W +: DMX_DATA_W];
    end

    logic                  grant_any;
    logic [PTR_W-1:0]      grant_idx;
    logic [PTR_W-1:0]      scan_idx;

    // Search upward from the pointer with wrap; the first valid requester wins.
    // A read strobe suppresses every grant so reads and writes never collide.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        if (state == ST_SERVE && !request_pulse) begin
            for (int off = 0; off < N_REQ; off++) begin
                scan_idx = PTR_W'((int'(rr_ptr) + off) % N_REQ);
                if (!grant_any && req_valid[scan_idx]) begin
                    grant_any = 1'b1;
                    grant_idx = scan_idx;
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    logic                  wr_en;
    logic [DMX_ADDR_W-1:0] wr_addr;
    logic [DMX_DATA_W-1:0] wr_data;

    // Writes to channel 0 are acknowledged but never stored.
    always_comb begin
        if (state == ST_CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = sweep_cnt;
            wr_data = CLR_VAL;
        end else begin
            wr_en   = grant_any && (req_addr_a[grant_idx] != '0);
            wr_addr = req_addr_a[grant_idx];
            wr_data = req_data_a[grant_idx];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_CLEAR;
            sweep_cnt <= '0;
            rr_ptr    <= '0;
        end else begin
            if (grant_any) begin
                rr_ptr <= (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
            case (state)
                ST_CLEAR: begin
                    if (clear) begin
                        sweep_cnt <= '0;
                    end else if (sweep_cnt == DMX_ADDR_W'(DMX_NUM_CH - 1)) begin
                        sweep_cnt <= '0;
                        state     <= ST_SERVE;
                    end else begin
                        sweep_cnt <= sweep_cnt + 1'b1;
                    end
                end
                ST_SERVE: begin
                    if (clear) begin
                        sweep_cnt <= '0;
                        state     <= ST_CLEAR;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

    assign busy = (state == ST_CLEAR);

    logic [DMX_DATA_W-1:0] ram_q_p0;

    dmx_channel_ram u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (request_pulse),
        .rd_addr (request_addr),
        .rd_data (ram_q_p0)
    );

    // Stage p0: RAM read registered, address and override flags captured.
    logic                  vld_p0;
    logic [DMX_ADDR_W-1:0] addr_p0;
    logic                  start_p0;
    logic                  clr_p0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= request_pulse;
        end
    end

    always_ff @(posedge clk) begin
        if (request_pulse) begin
            addr_p0  <= request_addr;
            start_p0 <= (request_addr == '0);
            clr_p0   <= (state == ST_CLEAR);
        end
    end

    // Stage p1: registered outputs, held until the next read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr <= '0;
            data <= '0;
        end else if (vld_p0) begin
            addr <= addr_p0;
            if (start_p0) begin
                data <= DMX_START_CODE;
            end else if (clr_p0) begin
                data <= CLR_VAL;
            end else begin
                data <= ram_q_p0;
            end
        end
    end

endmodule

// File: tb/tb_dmx_channel_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmx_channel_arbiter
// Scoreboard bench: every read pushes its expected {addr,data} at drive time;
// the monitor pops and compares when the registered outputs update.
// -----------------------------------------------------------------------------
module tb_dmx_channel_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         clear;
    logic [N-1:0] req_valid;
    logic [9*N-1:0] req_addr;
    logic [8*N-1:0] req_data;
    logic [N-1:0] req_ready;
    logic [8:0]   request_addr;
    logic         request_pulse;
    logic [8:0]   addr;
    logic [7:0]   data;
    logic         busy;

    dmx_channel_arbiter #(.N_REQ(N), .CLR_VAL(8'h00)) dut (
        .clk           (clk),
        .reset         (reset),
        .clear         (clear),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .request_addr  (request_addr),
        .request_pulse (request_pulse),
        .addr          (addr),
        .data          (data),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [8:0] a;
        logic [7:0] d;
    } rd_exp_t;

    rd_exp_t    exp_q [$];
    logic [7:0] shadow [512];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_rd(input int a);
        return (a == 0) ? 8'h00 : shadow[a];
    endfunction

    // Monitor: a strobe sampled at one edge is visible after the next edge.
    logic pend_p0, due_p1;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_p0 <= 1'b0;
            due_p1  <= 1'b0;
        end else begin
            pend_p0 <= request_pulse;
            due_p1  <= pend_p0;
        end
    end

    always @(negedge clk) begin
        rd_exp_t e;
        if (reset && due_p1) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("rd_addr", 32'(addr), 32'(e.a));
                chk("rd_data", 32'(data), 32'(e.d));
            end
        end
    end

    task automatic drive_read(input int a);
        request_pulse = 1'b1;
        request_addr  = 9'(a);
        exp_q.push_back('{a: 9'(a), d: exp_rd(a)});
    endtask

    task automatic read_seq(input int first, input int last);
        for (int a = first; a <= last; a++) begin
            @(negedge clk);
            drive_read(a);
        end
        @(negedge clk);
        request_pulse = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic write_one(input int i, input logic [8:0] a, input logic [7:0] d);
        bit got;
        got = 1'b0;
        @(negedge clk);
        req_valid[i]        = 1'b1;
        req_addr[i*9 +: 9]  = a;
        req_data[i*8 +: 8]  = d;
        for (int k = 0; k < 20 && !got; k++) begin
            #1;
            if (req_ready != '0) begin
                got = 1'b1;
                chk("wr_ready", 32'(req_ready), 32'(1 << i));
                if (a != 0) shadow[a] = d;
            end
            @(negedge clk);
        end
        req_valid[i] = 1'b0;
        if (!got) chk("wr_timeout", 0, 1);
        #1 chk("wr_ready_drop", 32'(req_ready), 0);
    endtask

    task automatic count_sweep(input string tag);
        int  busy_cnt;
        bit  seen_low;
        busy_cnt = 0;
        seen_low = 1'b0;
        for (int c = 0; c < 600 && !seen_low; c++) begin
            if (busy) begin
                busy_cnt++;
                chk("sweep_no_ready", 32'(req_ready), 0);
            end else begin
                seen_low = 1'b1;
            end
            if (!seen_low) @(negedge clk);
        end
        chk(tag, busy_cnt, 512);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  order [4];
        int  busy_cnt;
        bit  seen_low;
        bit  got;

        reset         = 1'b0;
        clear         = 1'b0;
        req_valid     = '1;
        req_addr      = {N{9'd3}};
        req_data      = {N{8'h11}};
        request_addr  = '0;
        request_pulse = 1'b0;
        for (int i = 0; i < 512; i++) shadow[i] = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_addr", 32'(addr), 0);
        chk("rst_data", 32'(data), 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_busy", 32'(busy), 1);
        req_valid = '0;

        // Sweep after reset with reads every cycle over 1..511
        @(negedge clk);
        reset    = 1'b1;
        busy_cnt = 0;
        seen_low = 1'b0;
        for (int c = 0; c < 520; c++) begin
            if (busy) begin
                if (seen_low) chk("busy_relapse", 1, 0);
                else busy_cnt++;
            end else begin
                seen_low = 1'b1;
            end
            if (c < 511) drive_read(c + 1);
            else request_pulse = 1'b0;
            @(negedge clk);
        end
        chk("busy_cycles", busy_cnt, 512);
        chk("busy_after", 32'(busy), 0);
        repeat (3) @(negedge clk);

        // Requester 1 writes channel 1, then readback
        write_one(1, 9'd1, 8'd53);
        read_seq(1, 1);

        // Four simultaneous requesters, pointer at 2
        order = '{2, 3, 0, 1};
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            req_addr[i*9 +: 9] = 9'(4 + i);
            req_data[i*8 +: 8] = 8'(170 + i);
        end
        req_valid = 4'hF;
        for (int g = 0; g < 4; g++) begin
            #1;
            chk("rr_order", 32'(req_ready), 32'(1 << order[g]));
            for (int i = 0; i < 4; i++) begin
                if (req_ready[i]) shadow[4 + i] = 8'(170 + i);
            end
            @(negedge clk);
            req_valid[order[g]] = 1'b0;
        end
        #1 chk("rr_idle", 32'(req_ready), 0);
        read_seq(4, 7);

        // Reads hold off requester 0 for 10 cycles
        @(negedge clk);
        req_valid[0]  = 1'b1;
        req_addr[8:0] = 9'd2;
        req_data[7:0] = 8'd242;
        for (int k = 0; k < 10; k++) begin
            drive_read(5);
            #1 chk("read_priority", 32'(req_ready), 0);
            @(negedge clk);
        end
        request_pulse = 1'b0;
        #1 chk("grant_after_reads", 32'(req_ready), 32'h1);
        if (req_ready[0]) shadow[2] = 8'd242;
        @(negedge clk);
        req_valid[0] = 1'b0;
        read_seq(2, 2);

        // Write to channel 0 is acknowledged but dropped
        write_one(2, 9'd0, 8'hFF);
        read_seq(0, 0);

        // Clear sweep, reset at sweep count 100, full restart
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear        = 1'b0;
        req_valid[3] = 1'b1;
        req_addr[27 +: 9] = 9'd9;
        req_data[24 +: 8] = 8'd77;
        for (int i = 0; i < 512; i++) shadow[i] = 8'h00;
        chk("clear_busy", 32'(busy), 1);
        for (int c = 0; c < 100; c++) begin
            #1 chk("clear_no_ready", 32'(req_ready), 0);
            @(negedge clk);
        end
        reset = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 1);
        chk("midrst_addr", 32'(addr), 0);
        chk("midrst_data", 32'(data), 0);
        chk("midrst_ready", 32'(req_ready), 0);
        @(negedge clk);
        reset = 1'b1;
        count_sweep("resweep_cycles");
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            #1;
            if (req_ready != '0) begin
                got = 1'b1;
                chk("post_sweep_grant", 32'(req_ready), 32'h8);
                shadow[9] = 8'd77;
            end
            @(negedge clk);
        end
        if (!got) chk("post_sweep_timeout", 0, 1);
        req_valid[3] = 1'b0;
        read_seq(0, 511);

        repeat (4) @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
